// File: rtl/ccr_controller_pkg.sv
// Shared definitions for the CCR controller: flag indices, jump/ALU encodings, update masks
// and the condition/mask decode helpers.
`default_nettype none

package ccr_controller_pkg;

    localparam int CCR_FLAG_W    = 4;
    localparam int CCR_ALU_SEL_W = 4;

    localparam int FLAG_V = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    localparam logic [2:0] JCOND_UNC = 3'd0;
    localparam logic [2:0] JCOND_Z   = 3'd1;
    localparam logic [2:0] JCOND_N   = 3'd2;
    localparam logic [2:0] JCOND_C   = 3'd3;
    localparam logic [2:0] JCOND_V   = 3'd4;

    localparam logic [CCR_ALU_SEL_W-1:0] ALU_NOP  = 4'd0;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_MOV  = 4'd1;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_INC  = 4'd2;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_DEC  = 4'd3;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_ADD  = 4'd4;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_SUB  = 4'd5;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_NOT  = 4'd6;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_AND  = 4'd7;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_OR   = 4'd8;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_SHL  = 4'd9;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_SHR  = 4'd10;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_SETC = 4'd11;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_LDD  = 4'd12;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_STD  = 4'd13;
    localparam logic [CCR_ALU_SEL_W-1:0] ALU_JMP  = 4'd14;

    localparam logic [CCR_FLAG_W-1:0] CCR_MASK_NONE = 4'b0000;
    localparam logic [CCR_FLAG_W-1:0] CCR_MASK_ALL  = 4'b1111;
    localparam logic [CCR_FLAG_W-1:0] CCR_MASK_ZN   = 4'b0110;
    localparam logic [CCR_FLAG_W-1:0] CCR_MASK_ZNC  = 4'b0111;
    localparam logic [CCR_FLAG_W-1:0] CCR_MASK_C    = 4'b0001;

    typedef enum logic [1:0] {
        SH_EMPTY   = 2'd0,
        SH_PARTIAL = 2'd1,
        SH_FULL    = 2'd2
    } shadow_state_e;

    function automatic logic [CCR_FLAG_W-1:0] ccr_update_mask(input logic [CCR_ALU_SEL_W-1:0] sel);
        case (sel)
            ALU_INC, ALU_DEC, ALU_ADD, ALU_SUB: ccr_update_mask = CCR_MASK_ALL;
            ALU_NOT, ALU_AND, ALU_OR:           ccr_update_mask = CCR_MASK_ZN;
            ALU_SHL, ALU_SHR:                   ccr_update_mask = CCR_MASK_ZNC;
            ALU_SETC:                           ccr_update_mask = CCR_MASK_C;
            default:                            ccr_update_mask = CCR_MASK_NONE;
        endcase
    endfunction

    function automatic logic cond_true(input logic [2:0] cond, input logic [CCR_FLAG_W-1:0] f);
        case (cond)
            JCOND_UNC: cond_true = 1'b1;
            JCOND_Z:   cond_true = f[FLAG_Z];
            JCOND_N:   cond_true = f[FLAG_N];
            JCOND_C:   cond_true = f[FLAG_C];
            JCOND_V:   cond_true = f[FLAG_V];
            default:   cond_true = 1'b0;
        endcase
    endfunction

    // One-hot mask of the flag a conditional jump tests (none for uncond/never).
    function automatic logic [CCR_FLAG_W-1:0] cond_flag_mask(input logic [2:0] cond);
        case (cond)
            JCOND_Z: cond_flag_mask = 4'b0100;
            JCOND_N: cond_flag_mask = 4'b0010;
            JCOND_C: cond_flag_mask = 4'b0001;
            JCOND_V: cond_flag_mask = 4'b1000;
            default: cond_flag_mask = 4'b0000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ccr_shadow_stack.sv
// NEST_DEPTH-entry LIFO holding the CCR across nested interrupts, with a sticky error flag
// for overflow, underflow and simultaneous push/pop.
`default_nettype none

module ccr_shadow_stack
    import ccr_controller_pkg::*;
#(
    parameter int FLAG_W     = CCR_FLAG_W,
    parameter int NEST_DEPTH = 2,
    parameter int DEPTH_W    = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [FLAG_W-1:0]  data_i,
    output logic [FLAG_W-1:0]  top_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               empty_o,
    output logic               err_o
);

    logic [FLAG_W-1:0]  entries_q [NEST_DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    shadow_state_e      state_q, state_d;
    logic               err_q, err_d;
    logic               do_push, do_pop;

    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        err_d   = err_q;
        depth_d = depth_q;
        if (push_i && pop_i) begin
            err_d = 1'b1;
        end else if (push_i) begin
            if (state_q == SH_FULL) begin
                err_d = 1'b1;
            end else begin
                do_push = 1'b1;
                depth_d = depth_q + DEPTH_W'(1);
            end
        end else if (pop_i) begin
            if (state_q == SH_EMPTY) begin
                err_d = 1'b1;
            end else begin
                do_pop  = 1'b1;
                depth_d = depth_q - DEPTH_W'(1);
            end
        end
        if (depth_d == '0)
            state_d = SH_EMPTY;
        else if (depth_d == DEPTH_W'(NEST_DEPTH))
            state_d = SH_FULL;
        else
            state_d = SH_PARTIAL;
    end

    always_comb begin
        top_o = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth_q)
                top_o = entries_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEST_DEPTH; i++)
                entries_q[i] <= '0;
            depth_q <= '0;
            state_q <= SH_EMPTY;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (do_push && DEPTH_W'(i) == depth_q)
                    entries_q[i] <= data_i;
                if (do_pop && DEPTH_W'(i + 1) == depth_q)
                    entries_q[i] <= '0;
            end
            depth_q <= depth_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign depth_o = depth_q;
    assign empty_o = (state_q == SH_EMPTY);
    assign err_o   = err_q;

endmodule

`default_nettype wire

// File: rtl/ccr_controller.sv
// Condition-code register controller: ALU flag merge, CLRC, conditional jumps and interrupt shadowing.
// Define CCR_FORWARD_EN to evaluate jumps on flags forwarded from the same cycle's ALU result.
`default_nettype none

module ccr_controller
    import ccr_controller_pkg::*;
#(
    parameter int FLAG_W     = CCR_FLAG_W,
    parameter int ALU_SEL_W  = CCR_ALU_SEL_W,
    parameter int NEST_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 stall,
    input  logic                                 flush,
    input  logic                                 alu_valid,
    input  logic [ALU_SEL_W-1:0]                 alu_sel,
    input  logic [FLAG_W-1:0]                    alu_flags,
    input  logic                                 clrc,
    input  logic                                 jmp_valid,
    input  logic [2:0]                           jmp_cond,
    input  logic                                 int_enter,
    input  logic                                 rti,
    output logic [FLAG_W-1:0]                    ccr,
    output logic                                 jmp_taken,
    output logic [$clog2(NEST_DEPTH+1)-1:0]      shadow_depth,
    output logic                                 shadow_err
);

    logic [FLAG_W-1:0] ccr_q, ccr_d;
    logic [FLAG_W-1:0] alu_mask, alu_wdata, alu_merged, soft_clear, flag_src, shadow_top;
    logic              shadow_empty;

    always_comb begin
        alu_mask   = (alu_valid && !flush) ? ccr_update_mask(alu_sel) : CCR_MASK_NONE;
        alu_wdata  = (alu_sel == ALU_SETC) ? CCR_MASK_C : alu_flags;
        alu_merged = (ccr_q & ~alu_mask) | (alu_wdata & alu_mask);
`ifdef CCR_FORWARD_EN
        flag_src   = alu_merged;
`else
        flag_src   = ccr_q;
`endif
        jmp_taken  = jmp_valid && !flush && !stall && cond_true(jmp_cond, flag_src);

        soft_clear = '0;
        if (clrc && !flush)
            soft_clear[FLAG_C] = 1'b1;
        if (jmp_taken)
            soft_clear = soft_clear | cond_flag_mask(jmp_cond);

        // Interrupt entry/return dominate every ALU, CLRC and jump-clear update.
        if (int_enter && rti)
            ccr_d = ccr_q;
        else if (rti)
            ccr_d = shadow_empty ? ccr_q : shadow_top;
        else if (int_enter)
            ccr_d = '0;
        else
            ccr_d = alu_merged & ~(soft_clear & ~alu_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ccr_q <= '0;
        else if (!stall)
            ccr_q <= ccr_d;
    end

    ccr_shadow_stack #(
        .FLAG_W     (FLAG_W),
        .NEST_DEPTH (NEST_DEPTH)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (int_enter && !stall),
        .pop_i   (rti && !stall),
        .data_i  (ccr_q),
        .top_o   (shadow_top),
        .depth_o (shadow_depth),
        .empty_o (shadow_empty),
        .err_o   (shadow_err)
    );

    assign ccr = ccr_q;

endmodule

`default_nettype wire

// File: tb/tb_ccr_controller.sv
// Directed self-checking bench for ccr_controller (NEST_DEPTH=2).
`default_nettype none

module tb_ccr_controller;
    import ccr_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, stall, flush, alu_valid, clrc, jmp_valid, int_enter, rti;
    logic [3:0] alu_sel, alu_flags;
    logic [2:0] jmp_cond;
    logic [3:0] ccr;
    logic       jmp_taken, shadow_err;
    logic [1:0] shadow_depth;

    int tests = 0;
    int fails = 0;

`ifdef CCR_FORWARD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    ccr_controller #(.NEST_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_flags(alu_flags),
        .clrc(clrc), .jmp_valid(jmp_valid), .jmp_cond(jmp_cond),
        .int_enter(int_enter), .rti(rti),
        .ccr(ccr), .jmp_taken(jmp_taken),
        .shadow_depth(shadow_depth), .shadow_err(shadow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 0; flush = 0; alu_valid = 0; alu_sel = ALU_NOP; alu_flags = 0;
        clrc = 0; jmp_valid = 0; jmp_cond = 0; int_enter = 0; rti = 0;
    endtask

    // Advance one clock edge, then return inputs to idle away from the edge.
    task automatic step();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic alu(input logic [3:0] sel, input logic [3:0] f);
        alu_valid = 1; alu_sel = sel; alu_flags = f;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #12;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #12;
        chk("reset_ccr", {4'b0, ccr}, 8'h0);
        chk("reset_depth", {6'b0, shadow_depth}, 8'h0);
        chk("reset_err", {7'b0, shadow_err}, 8'h0);
        chk("reset_jmp", {7'b0, jmp_taken}, 8'h0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Flag merge with masks
        alu(ALU_ADD, 4'b1011); step();
        chk("add_all", {4'b0, ccr}, 8'hB);
        alu(ALU_AND, 4'b0100); step();
        chk("and_zn_hold_vc", {4'b0, ccr}, 8'hD);
        alu(ALU_MOV, 4'b0000); step();
        chk("mov_none", {4'b0, ccr}, 8'hD);
        flush = 1; alu(ALU_ADD, 4'b0000); clrc = 1; step();
        chk("flush_ignored", {4'b0, ccr}, 8'hD);

        // Conditional jumps
        alu(ALU_ADD, 4'b0100); step();
        jmp_valid = 1; jmp_cond = JCOND_Z; #1;
        chk("jz_taken", {7'b0, jmp_taken}, 8'h1);
        step();
        chk("jz_clears_z", {4'b0, ccr}, 8'h0);
        jmp_valid = 1; jmp_cond = JCOND_C; #1;
        chk("jc_not_taken", {7'b0, jmp_taken}, 8'h0);
        jmp_cond = JCOND_UNC; #1;
        chk("uncond_taken", {7'b0, jmp_taken}, 8'h1);
        jmp_cond = 3'd6; #1;
        chk("never_cond", {7'b0, jmp_taken}, 8'h0);
        flush = 1; jmp_cond = JCOND_UNC; #1;
        chk("flush_jmp", {7'b0, jmp_taken}, 8'h0);
        step();
        alu(ALU_ADD, 4'b0100); step();
        alu(ALU_ADD, 4'b0100); jmp_valid = 1; jmp_cond = JCOND_Z; #1;
        chk("jz_with_alu_taken", {7'b0, jmp_taken}, 8'h1);
        step();
        chk("alu_beats_jclear", {4'b0, ccr}, 8'h4);

        // CLRC vs ALU
        alu(ALU_ADD, 4'b0001); step();
        alu(ALU_SHL, 4'b0001); clrc = 1; step();
        chk("alu_beats_clrc", {4'b0, ccr}, 8'h1);
        clrc = 1; step();
        chk("clrc_alone", {4'b0, ccr}, 8'h0);

        // Nested interrupts
        alu(ALU_ADD, 4'b1010); step();
        int_enter = 1; alu(ALU_ADD, 4'b1111); step();
        chk("enter1_ccr", {4'b0, ccr}, 8'h0);
        chk("enter1_depth", {6'b0, shadow_depth}, 8'h1);
        alu(ALU_ADD, 4'b0110); step();
        int_enter = 1; step();
        chk("enter2_depth", {6'b0, shadow_depth}, 8'h2);
        chk("enter2_err", {7'b0, shadow_err}, 8'h0);
        alu(ALU_ADD, 4'b0001); step();
        int_enter = 1; step();
        chk("enter3_ccr", {4'b0, ccr}, 8'h0);
        chk("enter3_depth", {6'b0, shadow_depth}, 8'h2);
        chk("enter3_err", {7'b0, shadow_err}, 8'h1);
        rti = 1; step();
        chk("rti1_ccr", {4'b0, ccr}, 8'h6);
        chk("rti1_depth", {6'b0, shadow_depth}, 8'h1);
        rti = 1; alu(ALU_ADD, 4'b1111); step();
        chk("rti2_ccr", {4'b0, ccr}, 8'hA);
        chk("rti2_depth", {6'b0, shadow_depth}, 8'h0);

        // Underflow
        do_reset();
        alu(ALU_ADD, 4'b0101); step();
        rti = 1; step();
        chk("rti_empty_ccr", {4'b0, ccr}, 8'h5);
        chk("rti_empty_depth", {6'b0, shadow_depth}, 8'h0);
        chk("rti_empty_err", {7'b0, shadow_err}, 8'h1);

        // Enter+rti collision at depth 1
        do_reset();
        alu(ALU_ADD, 4'b0101); step();
        int_enter = 1; step();
        alu(ALU_ADD, 4'b0011); step();
        chk("pre_collide_err", {7'b0, shadow_err}, 8'h0);
        int_enter = 1; rti = 1; alu(ALU_ADD, 4'b1000); step();
        chk("collide_ccr", {4'b0, ccr}, 8'h3);
        chk("collide_depth", {6'b0, shadow_depth}, 8'h1);
        chk("collide_err", {7'b0, shadow_err}, 8'h1);
        rti = 1; step();
        chk("after_collide_pop", {4'b0, ccr}, 8'h5);

        // SETC + JC same cycle, forwarding-dependent
        do_reset();
        alu(ALU_SETC, 4'b0000); jmp_valid = 1; jmp_cond = JCOND_C; #1;
        chk("setc_jc_taken", {7'b0, jmp_taken}, {7'b0, FWD});
        step();
        chk("setc_sets_c", {4'b0, ccr}, 8'h1);

        // Stall freezes everything
        do_reset();
        stall = 1; alu(ALU_SETC, 4'b0000); jmp_valid = 1; jmp_cond = JCOND_UNC; #1;
        chk("stall_jmp", {7'b0, jmp_taken}, 8'h0);
        @(posedge clk); #1;
        int_enter = 1;
        step();
        chk("stall_ccr", {4'b0, ccr}, 8'h0);
        chk("stall_depth", {6'b0, shadow_depth}, 8'h0);
        stall = 1; rti = 1; step();
        chk("stall_err", {7'b0, shadow_err}, 8'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
